// File: rtl/rf_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters between
// issue and writeback, driving the decode stall and busy/error status.
module rf_scoreboard #(
    parameter int MAX_INFLIGHT = 3,
    parameter int NREG         = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_vld,
    input  logic        issue_we,
    input  logic [3:0]  issue_dst,
    input  logic        src0_re,
    input  logic [3:0]  src0_addr,
    input  logic        src1_re,
    input  logic [3:0]  src1_addr,
    input  logic        wb_vld,
    input  logic [3:0]  wb_addr,
    input  logic        flush,
    output logic        stall,
    output logic [15:0] busy_vec,
    output logic [3:0]  busy_cnt,
    output logic        err
);

    localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

    logic [1:0]      cnt     [NREG];
    logic [1:0]      cnt_nxt [NREG];
    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] eff;
    logic [NREG-1:0] busy_nxt;
    logic [3:0]      busy_cnt_nxt;
    logic            err_nxt;
    logic            haz_r;
    logic            haz_s;
    logic            acc;

    // The RF writes in the high phase and reads in the low phase, so a
    // same-cycle writeback already releases the register for this cycle's read.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            wb_hit[i] = wb_vld && (wb_addr == 4'(i)) && (i != 0);
            eff[i]    = cnt[i] > {1'b0, wb_hit[i]};
        end
    end

    assign haz_r = (src0_re && eff[src0_addr]) || (src1_re && eff[src1_addr]);
    assign haz_s = issue_we && (issue_dst != 4'd0) &&
                   (cnt[issue_dst] == CNT_MAX) && !wb_hit[issue_dst];
    assign stall = issue_vld && !flush && (haz_r || haz_s);
    assign acc   = issue_vld && !stall && !flush && issue_we && (issue_dst != 4'd0);

    always_comb begin
        err_nxt      = err;
        busy_cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            inc[i]     = acc && (issue_dst == 4'(i));
            cnt_nxt[i] = cnt[i];
            if (flush || i == 0) begin
                cnt_nxt[i] = '0;
            end else if (wb_hit[i] && cnt[i] == 2'd0) begin
                // Writeback with nothing pending: it belongs to no tracked write.
                cnt_nxt[i] = {1'b0, inc[i]};
                err_nxt    = 1'b1;
            end else begin
                cnt_nxt[i] = cnt[i] + {1'b0, inc[i]} - {1'b0, wb_hit[i]};
            end
            busy_nxt[i]  = cnt_nxt[i] != 2'd0;
            busy_cnt_nxt = busy_cnt_nxt + 4'(busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '{default: '0};
            busy_vec <= '0;
            busy_cnt <= '0;
            err      <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            busy_vec <= busy_nxt;
            busy_cnt <= busy_cnt_nxt;
            err      <= err_nxt;
        end
    end

endmodule
